// File: rtl/memory_access_pkg.sv
// Shared MEM-stage definitions: access-size encodings, the MEM/WB register
// layout and the byte-lane helpers used by the load/store path.
package memory_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] ex_data;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;
    logic        misaligned;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input mem_size_e size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return 4'b0011 << off;
      default:   return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data across lanes; the byte enable picks the live one.
  function automatic logic [31:0] store_align(input mem_size_e size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: return {4{data[7:0]}};
      SIZE_HALF: return {2{data[15:0]}};
      default:   return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input mem_size_e size, input logic [1:0] off,
                                               input logic sgn, input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      SIZE_BYTE: return {{24{sgn & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: return {{16{sgn & shifted[15]}}, shifted[15:0]};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data memory: synchronous byte-enabled write, combinational read,
// so a read in the cycle after a write already sees the new data.
module dmem_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_access.sv
// MEM pipeline stage: aligned byte/half/word loads and stores against dmem_ram,
// misalignment detection and the MEM/WB register with stall/flush control.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic [4:0]  rd_in,
  output logic [31:0] mem_data,
  output logic [31:0] ex_data,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic        misaligned
);

  mem_size_e   size;
  logic [1:0]  off;
  logic        misaligned_access;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  mem_wb_t     wb_d, wb_q;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (ex_result[ADDR_W+1:2]),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_comb begin
    size              = mem_size_e'(MemSize);
    off               = ex_result[1:0];
    misaligned_access = (MemRead | MemWrite) & is_misaligned(size, off);
    mem_we            = rst_n & MemWrite & ~stall & ~flush & ~misaligned_access;
    mem_be            = byte_enable(size, off);
    mem_wdata         = store_align(size, ex_store_data);

    // NOTE: defaulting wb_d to the held value first keeps this block latch-free.
    wb_d = wb_q;
    if (flush) begin
      wb_d = MEM_WB_BUBBLE;
    end else if (!stall) begin
      wb_d.mem_data   = (MemRead & ~MemWrite) ? load_extract(size, off, MemSigned, mem_rdata)
                                              : 32'h0;
      wb_d.ex_data    = ex_result;
      wb_d.mem_to_reg = MemToReg_in;
      wb_d.reg_write  = RegWrite_in & ~misaligned_access;
      wb_d.rd         = rd_in;
      wb_d.misaligned = misaligned_access;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) wb_q <= MEM_WB_BUBBLE;
    else        wb_q <= wb_d;
  end

  assign mem_data   = wb_q.mem_data;
  assign ex_data    = wb_q.ex_data;
  assign MemToReg   = wb_q.mem_to_reg;
  assign RegWrite   = wb_q.reg_write;
  assign rd         = wb_q.rd;
  assign misaligned = wb_q.misaligned;

endmodule
